// File: rtl/bouncy_renderer.sv
// bouncy_renderer
//   Consumer end of the bouncy-object position interface. Position updates
//   arrive over valid/ready and are parked in a shadow register. They are
//   committed to the active position only at frame start, so a frame never
//   tears. A two-stage pixel pipeline turns the OLED driver's linear pixel
//   index into an RGB565 colour: a square sprite over a background, 96x64.
//
//   Optional feature: define BOUNCY_TRAIL_EN to keep the previously committed
//   position as well. Pixels inside that old box but outside the current box
//   are drawn in TR_COLOR. Without the macro only FG_COLOR and BG_COLOR are
//   produced.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   pos_x        in   7   object centre x
//   pos_y        in   6   object centre y
//   pos_valid    in   1   pos_x/pos_y valid
//   pos_ready    out  1   renderer can accept a position
//   frame_begin  in   1   one-cycle pulse at start of frame
//   pixel_index  in   13  pixel being fetched, y*SCR_W + x
//   pix_req      in   1   pixel_index valid this cycle
//   pix_valid    out  1   oled_data valid, two cycles after pix_req
//   oled_data    out  16  RGB565 colour for the requested pixel
module bouncy_renderer #(
    parameter int          SCR_W    = 96,
    parameter int          SCR_H    = 64,
    parameter int          HALF     = 2,
`ifdef BOUNCY_TRAIL_EN
    parameter logic [15:0] TR_COLOR = 16'h7BEF,
`endif
    parameter logic [15:0] FG_COLOR = 16'hF800,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  pos_x,
    input  logic [5:0]  pos_y,
    input  logic        pos_valid,
    output logic        pos_ready,
    input  logic        frame_begin,
    input  logic [12:0] pixel_index,
    input  logic        pix_req,
    output logic        pix_valid,
    output logic [15:0] oled_data
);

    localparam logic [12:0]        W13       = 13'(SCR_W);
    localparam logic [12:0]        PIX_TOTAL = 13'(SCR_W * SCR_H);
    localparam logic signed [7:0]  HALF_S    = 8'(HALF);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  shadow_x_q, shadow_x_d;
    logic [5:0]  shadow_y_q, shadow_y_d;
    logic [6:0]  active_x_q, active_x_d;
    logic [5:0]  active_y_q, active_y_d;
`ifdef BOUNCY_TRAIL_EN
    logic [6:0]  prev_x_q, prev_x_d;
    logic [5:0]  prev_y_q, prev_y_d;
`endif

    // Pixel pipeline registers
    logic        s1_valid_q;
    logic [6:0]  px_q;
    logic [6:0]  py_q;          // up to 85 for indices past the screen
    logic        in_rng_q;
    logic        pix_valid_q;
    logic [15:0] oled_q;
    logic [15:0] color_d;
    logic        hit;

    // Signed 8-bit distance test; no wrap, so a sprite at an edge is clipped.
    function automatic logic in_box(input logic [6:0] px, input logic [6:0] py,
                                    input logic [6:0] cx, input logic [5:0] cy);
        logic signed [7:0] dx;
        logic signed [7:0] dy;
        dx = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy = $signed({1'b0, py}) - $signed({2'b0, cy});
        return (dx >= -HALF_S) && (dx <= HALF_S) && (dy >= -HALF_S) && (dy <= HALF_S);
    endfunction

    // ---------------- position handshake FSM ----------------
    always_comb begin
        state_d    = state_q;
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        active_x_d = active_x_q;
        active_y_d = active_y_q;
`ifdef BOUNCY_TRAIL_EN
        prev_x_d   = prev_x_q;
        prev_y_d   = prev_y_q;
`endif
        pos_ready  = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (pos_valid && frame_begin) begin
                    // Arrived exactly at frame start: commit straight away.
                    active_x_d = pos_x;
                    active_y_d = pos_y;
`ifdef BOUNCY_TRAIL_EN
                    prev_x_d   = active_x_q;
                    prev_y_d   = active_y_q;
`endif
                end else if (pos_valid) begin
                    shadow_x_d = pos_x;
                    shadow_y_d = pos_y;
                    state_d    = PENDING;
                end
            end
            PENDING: begin
                if (frame_begin) begin
                    active_x_d = shadow_x_q;
                    active_y_d = shadow_y_q;
`ifdef BOUNCY_TRAIL_EN
                    prev_x_d   = active_x_q;
                    prev_y_d   = active_y_q;
`endif
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shadow_x_q <= '0;
            shadow_y_q <= '0;
            active_x_q <= '0;
            active_y_q <= '0;
`ifdef BOUNCY_TRAIL_EN
            prev_x_q   <= '0;
            prev_y_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            active_x_q <= active_x_d;
            active_y_q <= active_y_d;
`ifdef BOUNCY_TRAIL_EN
            prev_x_q   <= prev_x_d;
            prev_y_q   <= prev_y_d;
`endif
        end
    end

    // ---------------- pixel pipeline ----------------
    // Stage 2 reads the active position registers; a commit updates them on
    // a clock edge, so each compare sees one consistent position.
    always_comb begin
        hit     = in_rng_q && in_box(px_q, py_q, active_x_q, active_y_q);
        color_d = hit ? FG_COLOR : BG_COLOR;
`ifdef BOUNCY_TRAIL_EN
        if (in_rng_q && !hit && in_box(px_q, py_q, prev_x_q, prev_y_q)) begin
            color_d = TR_COLOR;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
            in_rng_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            oled_q      <= BG_COLOR;
        end else begin
            s1_valid_q  <= pix_req;
            px_q        <= 7'(pixel_index % W13);
            py_q        <= 7'(pixel_index / W13);
            in_rng_q    <= (pixel_index < PIX_TOTAL);
            pix_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                oled_q <= color_d;
            end
        end
    end

    assign pix_valid = pix_valid_q;
    assign oled_data = oled_q;

endmodule

// File: tb/tb_bouncy_renderer.sv
module tb_bouncy_renderer;

    localparam logic [15:0] FG = 16'hF800;
    localparam logic [15:0] BG = 16'h0000;
    localparam logic [15:0] TR = 16'h7BEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  pos_x;
    logic [5:0]  pos_y;
    logic        pos_valid;
    logic        pos_ready;
    logic        frame_begin;
    logic [12:0] pixel_index;
    logic        pix_req;
    logic        pix_valid;
    logic [15:0] oled_data;

    always #5 clk = ~clk;

    bouncy_renderer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_valid   (pos_valid),
        .pos_ready   (pos_ready),
        .frame_begin (frame_begin),
        .pixel_index (pixel_index),
        .pix_req     (pix_req),
        .pix_valid   (pix_valid),
        .oled_data   (oled_data)
    );

    int vectors = 0;
    int errs    = 0;
    int pv_count;

    // Reference model: positions as plain integers, a pending flag, and a
    // two-deep queue of expected outputs.
    int          m_ax, m_ay, m_sx, m_sy, m_px, m_py;
    bit          m_pend;
    bit          q_v [2];
    logic [15:0] q_c [2];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [15:0] ref_color(input int idx);
        int  x, y;
        bit  inr, h;
        x   = idx % 96;
        y   = idx / 96;
        inr = (idx < 96 * 64);
        h   = inr && iabs(x - m_ax) <= 2 && iabs(y - m_ay) <= 2;
        if (h) return FG;
`ifdef BOUNCY_TRAIL_EN
        if (inr && iabs(x - m_px) <= 2 && iabs(y - m_py) <= 2) return TR;
`endif
        return BG;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ax = 0; m_ay = 0; m_sx = 0; m_sy = 0; m_px = 0; m_py = 0;
        m_pend = 0;
        q_v[0] = 0; q_v[1] = 0;
        q_c[0] = BG; q_c[1] = BG;
    endtask

    // One clock: drive inputs, advance the model at the edge, then check.
    task automatic cyc(input bit fb, input bit pv, input int x, input int y,
                       input bit req, input int idx);
        frame_begin = fb;
        pos_valid   = pv;
        pos_x       = 7'(x);
        pos_y       = 6'(y);
        pix_req     = req;
        pixel_index = 13'(idx);
        @(posedge clk);
        q_v[1] = q_v[0];
        q_c[1] = q_c[0];
        if (!m_pend) begin
            if (pv && fb) begin
                m_px = m_ax; m_py = m_ay;
                m_ax = x % 128; m_ay = y % 64;
            end else if (pv) begin
                m_sx = x % 128; m_sy = y % 64;
                m_pend = 1;
            end
        end else if (fb) begin
            m_px = m_ax; m_py = m_ay;
            m_ax = m_sx; m_ay = m_sy;
            m_pend = 0;
        end
        q_v[0] = req;
        q_c[0] = req ? ref_color(idx % 8192) : BG;
        #1;
        check("pix_valid", 32'(pix_valid), 32'(q_v[1]));
        if (q_v[1]) check("oled_data", 32'(oled_data), 32'(q_c[1]));
        check("pos_ready", 32'(pos_ready), 32'(!m_pend));
        if (pix_valid) pv_count++;
    endtask

    task automatic req(input int idx);
        cyc(0, 0, 0, 0, 1, idx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        frame_begin = 0; pos_valid = 0; pix_req = 0;
        pos_x = 0; pos_y = 0; pixel_index = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pix_valid", 32'(pix_valid), 32'(0));
        check("rst_pos_ready", 32'(pos_ready), 32'(1));
        check("rst_oled_data", 32'(oled_data), 32'(BG));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int idx, dx, dy;
        rst_n = 1'b1;
        model_reset();
        #3;
        do_reset();

        // First pixel after reset.
        req(0);
        idle(2);

        // Position held in shadow until frame start.
        cyc(0, 1, 10, 20, 0, 0);
        cyc(0, 1, 10, 20, 1, 1930);     // producer still holding; ignored
        idle(2);
        cyc(1, 0, 0, 0, 0, 0);
        req(1930);
        req(1932);
        req(1933);
        idle(2);

        // Corner sprite, clipped and not wrapped.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        req(0);
        req(2);
        req(95);
        req(6143);
        idle(2);

        // Accept and commit in the same cycle.
        cyc(1, 1, 50, 30, 0, 0);
        req(2930);
        req(2928);
        req(2927);
        req(6144);
        req(8191);
        idle(2);

        // Sustained back-to-back requests.
        pv_count = 0;
        for (int i = 0; i < 100; i++) req(2830 + i);
        idle(2);
        check("b2b_count", 32'(pv_count), 32'(100));

        // Reset while a position is pending.
        cyc(0, 1, 70, 40, 0, 0);
        cyc(0, 1, 70, 40, 0, 0);
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        req(0);
        req(2930);
        req(40 * 96 + 70);
        idle(2);

        // Randomised traffic, biased towards the sprite neighbourhood.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                dx  = int'($urandom_range(0, 8)) - 4;
                dy  = int'($urandom_range(0, 8)) - 4;
                idx = (m_ay + dy) * 96 + m_ax + dx;
                if (idx < 0 || idx > 8191) idx = 0;
            end else begin
                idx = int'($urandom_range(0, 8191));
            end
            cyc(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
                int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
                ($urandom_range(0, 3) != 0), idx);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
